ldpc_qc_encoder: RTL and testbench

LDPC_QC_ENCODER -- requirements
Module: ldpc_qc_encoder

---
 rtl/ldpc_qc_encoder_if.sv | 26 ++
 rtl/ldpc_qc_encoder.sv | 167 ++++++++++++++++
 tb/tb_ldpc_qc_encoder.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ldpc_qc_encoder_if.sv
// ldpc_qc_encoder_if -- stream handshakes for the QC-LDPC encoder.
//   in_valid/in_ready/in_data      : info blocks into the encoder
//   out_valid/out_ready/out_data   : codeword blocks out of the encoder
//   out_last                       : final block of a codeword (qualified by out_valid)
// master = block driving info / accepting codeword; slave = encoder.
interface ldpc_qc_encoder_if #(
    parameter int D = 96
);
    logic         in_valid;
    logic         in_ready;
    logic [D-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [D-1:0] out_data;
    logic         out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/ldpc_qc_encoder.sv
// ldpc_qc_encoder -- quasi-cyclic LDPC encoder, one D-bit block per cycle.
// Accepts K info blocks, accumulating every parity block as the XOR of
// cyclically shifted info blocks (shift entry >= D means zero block), then
// emits the codeword blocks one per output handshake.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   gmtx      : C*K shift entries, entry (i,j) at [(i*K+j)*mtx_w +: mtx_w]
//   bus       : ldpc_qc_encoder_if.slave (info in, codeword out)
//   busy      : frame partially accepted or being emitted
// Build option: define LDPC_ENC_SYS_OUT_EN to buffer the info blocks and
// emit them ahead of the parity (systematic codeword, K+C blocks);
// otherwise only the C parity blocks are emitted.

// One parity row: the shifted contribution of the current info block.
module ldpc_qc_row #(
    parameter int D     = 96,
    parameter int K     = 12,
    parameter int CW    = 5,
    parameter int mtx_w = 8
) (
    input  logic [D-1:0]       x,
    input  logic [K*mtx_w-1:0] row,
    input  logic [CW-1:0]      sel,
    output logic [D-1:0]       y
);
    logic [mtx_w-1:0] s;
    logic [2*D-1:0]   rot;

    always_comb begin
        s = '1;
        for (int j = 0; j < K; j++) begin
            if (sel == CW'(j)) s = row[j*mtx_w +: mtx_w];
        end
        // bit k of the low half is x[(k+s) mod D]
        rot = {x, x} >> s;
        y   = (int'(s) >= D) ? '0 : rot[D-1:0];
    end
endmodule

module ldpc_qc_encoder #(
    parameter int D     = 96,
    parameter int K     = 12,
    parameter int C     = 12,
    parameter int mtx_w = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [C*K*mtx_w-1:0]   gmtx,
    ldpc_qc_encoder_if.slave       bus,
    output logic                   busy
);
    localparam int CW = $clog2(K + C);
`ifdef LDPC_ENC_SYS_OUT_EN
    localparam int NOUT = K + C;
    localparam int POFS = K;
`else
    localparam int NOUT = C;
    localparam int POFS = 0;
`endif
    localparam logic [CW-1:0] LAST_IN  = CW'(K - 1);
    localparam logic [CW-1:0] LAST_OUT = CW'(NOUT - 1);

    typedef enum logic {FILL, EMIT} state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [C-1:0][D-1:0] acc_q, acc_d;
    logic [C-1:0][D-1:0] contrib;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic [D-1:0]        out_data_q, out_data_d;
    logic                in_fire, out_fire;
`ifdef LDPC_ENC_SYS_OUT_EN
    logic [K-1:0][D-1:0] ibuf_q, ibuf_d;
`endif

    for (genvar i = 0; i < C; i++) begin : g_row
        ldpc_qc_row #(.D(D), .K(K), .CW(CW), .mtx_w(mtx_w)) u_row (
            .x   (bus.in_data),
            .row (gmtx[i*K*mtx_w +: K*mtx_w]),
            .sel (cnt_q),
            .y   (contrib[i])
        );
    end

    assign bus.in_ready  = (state_q == FILL);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign busy          = (state_q == EMIT) || (cnt_q != '0);

    assign in_fire  = bus.in_valid && (state_q == FILL);
    assign out_fire = bus.out_ready && out_valid_q && (state_q == EMIT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
`ifdef LDPC_ENC_SYS_OUT_EN
        ibuf_d  = ibuf_q;
`endif
        if (state_q == FILL) begin
            if (in_fire) begin
                for (int i = 0; i < C; i++) acc_d[i] = acc_q[i] ^ contrib[i];
`ifdef LDPC_ENC_SYS_OUT_EN
                for (int j = 0; j < K; j++) begin
                    if (cnt_q == CW'(j)) ibuf_d[j] = bus.in_data;
                end
`endif
                if (cnt_q == LAST_IN) begin
                    state_d = EMIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end else if (out_fire) begin
            if (cnt_q == LAST_OUT) begin
                state_d = FILL;
                cnt_d   = '0;
                acc_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        // Output registers are loaded from next-state values so the block
        // appears the cycle after entering EMIT and holds while stalled.
        out_valid_d = (state_d == EMIT);
        out_last_d  = out_valid_d && (cnt_d == LAST_OUT);
        out_data_d  = '0;
        if (out_valid_d) begin
`ifdef LDPC_ENC_SYS_OUT_EN
            for (int j = 0; j < K; j++) begin
                if (cnt_d == CW'(j)) out_data_d = ibuf_d[j];
            end
`endif
            for (int i = 0; i < C; i++) begin
                if (cnt_d == CW'(POFS + i)) out_data_d = acc_d[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
`ifdef LDPC_ENC_SYS_OUT_EN
            ibuf_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
`ifdef LDPC_ENC_SYS_OUT_EN
            ibuf_q      <= ibuf_d;
`endif
        end
    end
endmodule

// File: tb/tb_ldpc_qc_encoder.sv
// tb_ldpc_qc_encoder -- self-checking bench for ldpc_qc_encoder: directed
// table vectors with hand-derived parity, randomized frames against a
// bit-level reference model, stall, reset and back-to-back sequences.
module tb_ldpc_qc_encoder;
    localparam int D  = 96;
    localparam int K  = 12;
    localparam int C  = 12;
    localparam int MW = 8;
`ifdef LDPC_ENC_SYS_OUT_EN
    localparam int NOUT = K + C;
    localparam int POFS = K;
`else
    localparam int NOUT = C;
    localparam int POFS = 0;
`endif

    typedef logic [D-1:0] blk_t;
    typedef struct {
        logic [7:0] g00;
        logic [7:0] g01;
        blk_t       b0;
        blk_t       b1;
        blk_t       p0;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [C*K*MW-1:0]    gmtx;
    logic                 busy;

    ldpc_qc_encoder_if #(.D(D)) bus();

    ldpc_qc_encoder #(.D(D), .K(K), .C(C), .mtx_w(MW)) dut (
        .clk  (clk),
        .rst  (rst),
        .gmtx (gmtx),
        .bus  (bus.slave),
        .busy (busy)
    );

    always #5 clk = ~clk;

    logic [7:0] gm   [C][K];
    blk_t       info [2][K];
    blk_t       expv [2][NOUT];
    blk_t       got  [2][NOUT];
    vec_t       vt   [8];
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic chk(input string nm, input blk_t act, input blk_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic pack_gm();
        for (int i = 0; i < C; i++)
            for (int j = 0; j < K; j++)
                gmtx[(i*K+j)*MW +: MW] = gm[i][j];
    endtask

    task automatic set_gm_all(input logic [7:0] v);
        for (int i = 0; i < C; i++)
            for (int j = 0; j < K; j++)
                gm[i][j] = v;
    endtask

    function automatic blk_t rnd_blk();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic rnd_frame(input int sel);
        for (int j = 0; j < K; j++) info[sel][j] = rnd_blk();
    endtask

    task automatic rnd_gm();
        for (int i = 0; i < C; i++)
            for (int j = 0; j < K; j++)
                gm[i][j] = ($urandom_range(0, 3) == 0) ? 8'hff : 8'($urandom_range(0, D - 1));
    endtask

    // Reference: parity bit k of row i is the XOR over info blocks j of
    // info[j][(k+s) mod D], skipping entries s >= D.
    task automatic model(input int sel);
        for (int i = 0; i < C; i++) begin
            blk_t p = '0;
            for (int j = 0; j < K; j++) begin
                int s = int'(gm[i][j]);
                if (s < D)
                    for (int k = 0; k < D; k++)
                        p[k] = p[k] ^ info[sel][j][(k + s) % D];
            end
            expv[sel][POFS + i] = p;
        end
`ifdef LDPC_ENC_SYS_OUT_EN
        for (int j = 0; j < K; j++) expv[sel][j] = info[sel][j];
`endif
    endtask

    task automatic send(input int sel, input int n, input bit keep);
        for (int j = 0; j < n; j++) begin
            int t = 0;
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = info[sel][j];
            while (!bus.in_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            chk($sformatf("in_ready_wait f%0d b%0d", sel, j), blk_t'(bus.in_ready), blk_t'(1));
            @(posedge clk);
        end
        if (!keep) begin
            #1 bus.in_valid = 1'b0;
        end
    endtask

    task automatic recv(input int sel, input int stall_at);
        bus.out_ready = 1'b1;
        for (int b = 0; b < NOUT; b++) begin
            int t = 0;
            @(negedge clk);
            if (b == stall_at) begin
                blk_t held;
                bus.out_ready = 1'b0;
                held = bus.out_data;
                for (int s = 0; s < 10; s++) begin
                    @(negedge clk);
                    chk($sformatf("stall_valid c%0d", s), blk_t'(bus.out_valid), blk_t'(1));
                    chk($sformatf("stall_data c%0d", s), bus.out_data, held);
                    chk($sformatf("stall_in_ready c%0d", s), blk_t'(bus.in_ready), blk_t'(0));
                end
                bus.out_ready = 1'b1;
            end
            while (!bus.out_valid && t < 200) begin
                @(negedge clk);
                t++;
            end
            chk($sformatf("out_valid_wait f%0d b%0d", sel, b), blk_t'(bus.out_valid), blk_t'(1));
            got[sel][b] = bus.out_data;
            chk($sformatf("out_last f%0d b%0d", sel, b), blk_t'(bus.out_last),
                blk_t'(b == NOUT - 1));
            @(posedge clk);
        end
        @(negedge clk);
        chk($sformatf("in_ready_after_last f%0d", sel), blk_t'(bus.in_ready), blk_t'(1));
        chk($sformatf("busy_after_last f%0d", sel), blk_t'(busy), blk_t'(0));
    endtask

    task automatic cmp_frame(input int sel, input string nm);
        for (int b = 0; b < NOUT; b++)
            chk($sformatf("%s blk%0d", nm, b), got[sel][b], expv[sel][b]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        blk_t pat;
        blk_t one;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        set_gm_all(8'hff);
        pack_gm();

        // reset state
        #1;
        chk("rst out_valid", blk_t'(bus.out_valid), blk_t'(0));
        chk("rst out_last",  blk_t'(bus.out_last),  blk_t'(0));
        chk("rst out_data",  bus.out_data,          blk_t'(0));
        chk("rst busy",      blk_t'(busy),          blk_t'(0));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst in_ready", blk_t'(bus.in_ready), blk_t'(1));

        // directed table: row 0 driven by blocks 0/1, everything else zero
        one = '0;
        one[0] = 1'b1;
        pat = rnd_blk();
        vt[0] = '{8'd5,   8'hff, one,      '0,  blk_t'(1) << 91};
        vt[1] = '{8'd0,   8'hff, one << 5, '0,  one << 5};
        vt[2] = '{8'd1,   8'hff, one,      '0,  one << 95};
        vt[3] = '{8'd3,   8'd3,  pat,      pat, '0};
        vt[4] = '{8'hff,  8'hff, pat,      pat, '0};
        vt[5] = '{8'd96,  8'hff, one,      '0,  '0};
        vt[6] = '{8'd95,  8'hff, one,      '0,  one << 1};
        vt[7] = '{8'd0,   8'd1,  one,      one, one | (one << 95)};
        for (int v = 0; v < 8; v++) begin
            set_gm_all(8'hff);
            gm[0][0] = vt[v].g00;
            gm[0][1] = vt[v].g01;
            pack_gm();
            for (int j = 0; j < K; j++) info[0][j] = '0;
            info[0][0] = vt[v].b0;
            info[0][1] = vt[v].b1;
            send(0, K, 1'b0);
            recv(0, -1);
            for (int c = 0; c < C; c++)
                chk($sformatf("vec%0d parity%0d", v, c), got[0][POFS + c],
                    (c == 0) ? vt[v].p0 : blk_t'(0));
`ifdef LDPC_ENC_SYS_OUT_EN
            for (int j = 0; j < K; j++)
                chk($sformatf("vec%0d info%0d", v, j), got[0][j], info[0][j]);
`endif
        end

        // all-zero generator, random info: parity must be zero
        set_gm_all(8'hff);
        pack_gm();
        rnd_frame(0);
        send(0, K, 1'b0);
        recv(0, -1);
        for (int c = 0; c < C; c++)
            chk($sformatf("zero_gm parity%0d", c), got[0][POFS + c], '0);
`ifdef LDPC_ENC_SYS_OUT_EN
        for (int j = 0; j < K; j++)
            chk($sformatf("zero_gm info%0d", j), got[0][j], info[0][j]);
`endif

        // random frames against the model, one with a mid-EMIT stall
        for (int f = 0; f < 4; f++) begin
            rnd_gm();
            pack_gm();
            rnd_frame(0);
            model(0);
            send(0, K, 1'b0);
            recv(0, (f == 1) ? NOUT / 2 : -1);
            cmp_frame(0, $sformatf("rand%0d", f));
        end

        // reset after 5 accepted blocks, then a clean frame
        rnd_frame(0);
        send(0, 5, 1'b0);
        @(negedge clk);
        chk("mid busy", blk_t'(busy), blk_t'(1));
        rst = 1'b1;
        #1;
        chk("midrst busy",      blk_t'(busy),          blk_t'(0));
        chk("midrst out_valid", blk_t'(bus.out_valid), blk_t'(0));
        chk("midrst in_ready",  blk_t'(bus.in_ready),  blk_t'(1));
        @(negedge clk);
        rst = 1'b0;
        rnd_frame(0);
        model(0);
        send(0, K, 1'b0);
        recv(0, -1);
        cmp_frame(0, "after_rst");

        // reset while EMIT is stalled clears the output immediately
        rnd_frame(0);
        bus.out_ready = 1'b0;
        send(0, K, 1'b0);
        @(negedge clk);
        chk("emit out_valid", blk_t'(bus.out_valid), blk_t'(1));
        rst = 1'b1;
        #1;
        chk("emitrst out_valid", blk_t'(bus.out_valid), blk_t'(0));
        chk("emitrst out_data",  bus.out_data,          blk_t'(0));
        chk("emitrst busy",      blk_t'(busy),          blk_t'(0));
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;

        // back-to-back frames with in_valid held high across EMIT
        rnd_gm();
        pack_gm();
        rnd_frame(0);
        rnd_frame(1);
        model(0);
        model(1);
        fork
            begin
                send(0, K, 1'b1);
                send(1, K, 1'b0);
            end
            begin
                recv(0, -1);
                recv(1, -1);
            end
        join
        cmp_frame(0, "b2b0");
        cmp_frame(1, "b2b1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
